// File: rtl/dco_pkg.sv
// dco_pkg: shared definitions for the DCO bank.
//   BASE_HALF_DEF / DEFAULT_HALF_DEF : default half-period constants
//   MAX_CH                           : largest supported channel count
//   dco_mode_e                       : output mode encodings (square / pulse)
//   encode_half()                    : frequency code -> half-period
package dco_pkg;

    localparam int BASE_HALF_DEF    = 3;
    localparam int DEFAULT_HALF_DEF = 50;
    localparam int MAX_CH           = 8;

    typedef enum logic {
        MODE_SQUARE = 1'b0,
        MODE_PULSE  = 1'b1
    } dco_mode_e;

    // Priority encoder: the highest set bit k selects base_half + k.
    // An all-zero code falls back to default_half.
    function automatic int encode_half(
        input logic [31:0] code,
        input int          base_half,
        input int          default_half
    );
        int half;
        half = default_half;
        for (int i = 0; i < 32; i++) begin
            if (code[i]) begin
                half = base_half + i;
            end
        end
        return half;
    endfunction

endpackage

// File: rtl/dco_bank_if.sv
// dco_bank_if: frequency-code write port of the DCO bank.
//   code_valid : write request (master -> slave)
//   code_ch    : target channel (master -> slave)
//   code_data  : frequency code (master -> slave)
//   code_ready : write can be accepted (slave -> master)
interface dco_bank_if #(
    parameter int NUM_CH = 4,
    parameter int CODE_W = 8
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic              code_valid;
    logic [CH_W-1:0]   code_ch;
    logic [CODE_W-1:0] code_data;
    logic              code_ready;

    modport master (
        output code_valid,
        output code_ch,
        output code_data,
        input  code_ready
    );

    modport slave (
        input  code_valid,
        input  code_ch,
        input  code_data,
        output code_ready
    );
endinterface

// File: rtl/dco_channel.sv
// dco_channel: one oscillator channel.
//   clk, rst    : clock, asynchronous active-high reset
//   en          : run enable; low holds the channel in its restart state
//   pulse_mode  : 0 square wave, 1 one-cycle pulse per period
//   sync_start  : restart strobe shared by all channels
//   wr_en       : capture wr_half as the pending half-period
//   wr_half     : encoded half-period being written
//   pending     : a written half-period is waiting to be applied
//   dco_out     : registered oscillator output
//   update_done : one-cycle pulse when the pending half-period is loaded
module dco_channel
    import dco_pkg::*;
#(
    parameter int CNT_W        = 8,
    parameter int DEFAULT_HALF = DEFAULT_HALF_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             pulse_mode,
    input  logic             sync_start,
    input  logic             wr_en,
    input  logic [CNT_W-1:0] wr_half,
    output logic             pending,
    output logic             dco_out,
    output logic             update_done
);

    logic [CNT_W-1:0] cnt_reg,       cnt_next;
    logic [CNT_W-1:0] half_reg,      half_next;
    logic [CNT_W-1:0] pend_half_reg, pend_half_next;
    logic             pend_reg,      pend_next;
    logic             state_reg,     state_next;
    logic             out_reg,       out_next;
    logic             done_reg,      done_next;
    logic             load;

    always_comb begin
        cnt_next       = cnt_reg;
        half_next      = half_reg;
        pend_half_next = pend_half_reg;
        pend_next      = pend_reg;
        state_next     = state_reg;
        load           = 1'b0;

        // A restart (sync or disabled) is also a safe point to switch the
        // half-period, since the waveform restarts from a clean low phase.
        if (sync_start || !en) begin
            cnt_next   = '0;
            state_next = 1'b0;
            load       = pend_reg;
        end else if (cnt_reg == half_reg) begin
            cnt_next   = '0;
            state_next = !state_reg;
            load       = pend_reg;
        end else begin
            cnt_next   = cnt_reg + CNT_W'(1);
        end

        if (load) begin
            half_next = pend_half_reg;
            pend_next = 1'b0;
        end

        // wr_en is only raised while nothing is pending, so it never meets
        // a load in the same cycle; a fresh write waits for the next boundary.
        if (wr_en) begin
            pend_next      = 1'b1;
            pend_half_next = wr_half;
        end

        if (dco_mode_e'(pulse_mode) == MODE_PULSE) begin
            out_next = state_next && !state_reg;
        end else begin
            out_next = state_next;
        end
        done_next = load;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg       <= '0;
            half_reg      <= CNT_W'(DEFAULT_HALF);
            pend_half_reg <= '0;
            pend_reg      <= 1'b0;
            state_reg     <= 1'b0;
            out_reg       <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            cnt_reg       <= cnt_next;
            half_reg      <= half_next;
            pend_half_reg <= pend_half_next;
            pend_reg      <= pend_next;
            state_reg     <= state_next;
            out_reg       <= out_next;
            done_reg      <= done_next;
        end
    end

    assign pending     = pend_reg;
    assign dco_out     = out_reg;
    assign update_done = done_reg;

endmodule

// File: rtl/dco_bank.sv
// dco_bank: multi-channel digital clock oscillator bank.
//   clk, rst    : clock, asynchronous active-high reset
//   en          : per-channel run enable
//   pulse_mode  : 0 square wave, 1 one-cycle pulse per period
//   sync_start  : restarts all channels in phase
//   code_if     : frequency-code write port (valid/ready)
//   dco_out     : oscillator outputs
//   update_done : per-channel pulse when a new half-period takes effect
module dco_bank
    import dco_pkg::*;
#(
    parameter int NUM_CH       = 4,
    parameter int CODE_W       = 8,
    parameter int CNT_W        = 8,
    parameter int BASE_HALF    = BASE_HALF_DEF,
    parameter int DEFAULT_HALF = DEFAULT_HALF_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] en,
    input  logic              pulse_mode,
    input  logic              sync_start,
    dco_bank_if.slave         code_if,
    output logic [NUM_CH-1:0] dco_out,
    output logic [NUM_CH-1:0] update_done
);

    localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CH_SPAN  = 1 << CH_W;
    localparam int TOP_HALF = BASE_HALF + CODE_W - 1;
    localparam int MAX_HALF = (DEFAULT_HALF > TOP_HALF) ? DEFAULT_HALF : TOP_HALF;
    localparam bit HALF_FITS = (CNT_W >= 31) || (MAX_HALF < (1 << CNT_W));

    generate
        if (NUM_CH < 1 || NUM_CH > MAX_CH || CODE_W > 32 || !HALF_FITS) begin : g_bad_params
            $error("dco_bank: NUM_CH out of range or CNT_W too narrow for the largest half-period");
        end
    endgenerate

    logic [NUM_CH-1:0]  pending;
    logic [CH_SPAN-1:0] pending_span;
    logic               ch_in_range;
    logic               accept;
    logic [CNT_W-1:0]   wr_half;

    // Widen the pending vector to the full code_ch range so an out-of-range
    // channel number never indexes past the end; such writes are refused.
    assign pending_span       = CH_SPAN'(pending);
    assign ch_in_range        = int'(code_if.code_ch) < NUM_CH;
    assign code_if.code_ready = ch_in_range && !pending_span[code_if.code_ch];
    assign accept             = code_if.code_valid && code_if.code_ready;
    assign wr_half = CNT_W'(encode_half(32'(code_if.code_data), BASE_HALF, DEFAULT_HALF));

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic wr_en;
            assign wr_en = accept && (code_if.code_ch == CH_W'(gi));

            dco_channel #(
                .CNT_W        (CNT_W),
                .DEFAULT_HALF (DEFAULT_HALF)
            ) u_channel (
                .clk         (clk),
                .rst         (rst),
                .en          (en[gi]),
                .pulse_mode  (pulse_mode),
                .sync_start  (sync_start),
                .wr_en       (wr_en),
                .wr_half     (wr_half),
                .pending     (pending[gi]),
                .dco_out     (dco_out[gi]),
                .update_done (update_done[gi])
            );
        end
    endgenerate

endmodule
